// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Handshaked ALU that sits between the operand stage and writeback.
//   ADD, SUB, AND, OR and SLT complete one cycle after accept. MUL (shift-add,
//   LSB first) and DIVU/REMU (restoring, MSB first) iterate over WIDTH cycles
//   and complete WIDTH+1 cycles after accept.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operation request handshake
//   a, b, alu_op         operands and op code (8-15 are illegal)
//   out_valid / out_ready result handshake
//   result, zero, illegal registered result and flags
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE and out_valid only in DONE,
// both decoded from the state register alone. The producer's a/b/alu_op are
// sampled only on the accepting edge, and result/zero/illegal are held
// constant for as long as out_valid is high.

module multicycle_alu #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_DIVU = 4'd6;
  localparam logic [3:0] OP_REMU = 4'd7;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  // x_q: multiplicand (MUL) or dividend shifting into quotient (DIV/REM)
  // y_q: multiplier (MUL) or divisor (DIV/REM)
  // acc_q: partial product (MUL) or partial remainder (DIV/REM)
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Single-cycle path, evaluated on the raw inputs at accept time.
  logic [WIDTH-1:0] fast_res;
  logic             fast_ill;
  logic             is_multi;

  always_comb begin
    fast_res = '0;
    fast_ill = alu_op[3];
    is_multi = 1'b0;
    case (alu_op)
      OP_ADD:  fast_res = a + b;
      OP_SUB:  fast_res = a - b;
      OP_AND:  fast_res = a & b;
      OP_OR:   fast_res = a | b;
      OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MUL, OP_DIVU, OP_REMU: is_multi = 1'b1;
      default: fast_res = '0;
    endcase
  end

  // One iteration step of the multi-cycle ops.
  logic [WIDTH-1:0] mul_acc_n;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem_n;
  logic [WIDTH-1:0] div_quo_n;
  logic             is_mul;
  logic [WIDTH-1:0] iter_x;
  logic [WIDTH-1:0] iter_y;
  logic [WIDTH-1:0] iter_acc;
  logic [WIDTH-1:0] iter_res;

  always_comb begin
    mul_acc_n = y_q[0] ? (acc_q + x_q) : acc_q;
    // Bring down the next dividend bit; a non-negative trial sets the
    // quotient bit. With a zero divisor every trial succeeds, so the
    // quotient becomes all ones and the remainder collects the dividend.
    rem_sh    = {acc_q, x_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, y_q};
    div_ok    = ~trial[WIDTH];
    div_rem_n = div_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_quo_n = {x_q[WIDTH-2:0], div_ok};
    is_mul    = (op_q == OP_MUL);
    iter_x    = is_mul ? (x_q << 1) : div_quo_n;
    iter_y    = is_mul ? (y_q >> 1) : y_q;
    iter_acc  = is_mul ? mul_acc_n : div_rem_n;
    iter_res  = (op_q == OP_DIVU) ? div_quo_n : iter_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= OP_ADD;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= alu_op;
            if (is_multi) begin
              x_q   <= a;
              y_q   <= b;
              acc_q <= '0;
              cnt   <= CNT_W'(WIDTH);
              state <= S_BUSY;
            end else begin
              result_q  <= fast_res;
              zero_q    <= (fast_res == '0);
              illegal_q <= fast_ill;
              state     <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          x_q   <= iter_x;
          y_q   <= iter_y;
          acc_q <= iter_acc;
          cnt   <= cnt - CNT_W'(1);
          // The last iteration writes its result directly so DONE is
          // reached on the same edge the counter hits zero.
          if (cnt == CNT_W'(1)) begin
            result_q  <= iter_res;
            zero_q    <= (iter_res == '0);
            illegal_q <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, handshaked ALU for the next-generation datapath.
- Keeps the single-cycle logic ops (ADD, SUB, AND, OR).
- Adds signed compare, plus iterative multiply and unsigned divide/remainder computed over WIDTH cycles.
- Sits between the decode/operand stage and writeback. It stalls the pipeline through in_ready/out_valid instead of completing combinationally.

Parameters:
- WIDTH, 64: operand and result width in bits; any value >= 8.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_op  input  4  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 MUL (low WIDTH bits), 6 DIVU, 7 REMU; 8-15 illegal.
- out_valid  output  1  result, zero and illegal are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- illegal  output  1  the completed op code was 8-15.

Behaviour:
- State machine with three states: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are combinational from the state register only.
- Accept: in_valid && in_ready on an edge. a, b and alu_op are captured; later input changes are ignored.
- Single-cycle ops (0-4, illegal):
  - On accept, result/zero/illegal are registered and the state goes to DONE.
  - out_valid is high in the cycle after accept, so latency is 1.
- MUL (op 5):
  - Shift-add, one multiplier bit per cycle, LSB first.
  - On accept the state goes to BUSY with the counter at WIDTH.
  - The counter decrements each cycle. When it reaches 0, the state goes to DONE.
  - out_valid rises WIDTH+1 cycles after accept.
  - The result is the low WIDTH bits of the product. The result is the same for signed and unsigned operands.
- DIVU/REMU (ops 6, 7):
  - Restoring division, one quotient bit per cycle, MSB first.
  - Same BUSY/counter timing as MUL: WIDTH+1 cycles.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero (b == 0):
  - No trap and no early exit; the latency stays WIDTH+1.
  - DIVU returns all-ones. REMU returns a.
- SLT: result = 1 if $signed(a) < $signed(b), else 0, zero-extended to WIDTH.
- ADD/SUB wrap modulo 2^WIDTH. No carry or overflow outputs.
- Illegal op: result = 0, zero = 1, illegal = 1, latency 1. The ALU does not hang.
- DONE:
  - result, zero and illegal hold stable while out_valid && !out_ready.
  - When out_ready is high, the state goes to IDLE on that edge and in_ready rises the next cycle.
  - There is no same-cycle accept of a new op in DONE. Back-to-back single-cycle throughput is one op per 2 cycles.
- BUSY: in_ready = 0 and out_ready is ignored. No abort input exists.
- Reset (rst_n low, any state, including mid-iteration):
  - state = IDLE, counter = 0, result = 0, zero = 1, illegal = 0.
  - out_valid = 0, in_ready = 1 after release.
  - Any partial product or quotient is discarded.
- zero and illegal are registered together with result, so they are never combinational from a/b.

Test Plan:
- Reset mid-MUL: accept a=3, b=5 op 5, assert rst_n low at cycle 10 -> out_valid=0, result=0, zero=1; after release in_ready=1 and there is no spurious out_valid.
- ADD and SUB, WIDTH=64:
  - a=64'hFFFF_FFFF_FFFF_FFFF, b=1, op 0 -> out_valid 1 cycle after accept, result=0, zero=1.
  - a=5, b=7, op 1 -> result=64'hFFFF_FFFF_FFFF_FFFE, zero=0.
- MUL: a=64'h1_0000_0001, b=64'h1_0000_0001 -> out_valid exactly 65 cycles after accept, result=64'h2_0000_0001.
- DIVU/REMU:
  - a=100, b=7 -> DIVU 14, REMU 2, each with 65-cycle latency.
  - a=9, b=0 -> DIVU all-ones, REMU 9.
- SLT and illegal:
  - a=-1, b=1 -> result 1.
  - a=1, b=-1 -> result 0.
  - op 12 -> result 0, zero 1, illegal 1, latency 1.
- Backpressure: complete ADD 2+3 with out_ready held low 4 cycles -> result=5 stays stable, in_ready=0, and a/b changes are ignored; out_ready high -> IDLE, in_ready=1 the next cycle.
